i2s_capture_ctrl: RTL and testbench

- Sequencer between the I2S microphone receiver and the DMA controller.
- Enables the receiver and gates capture on the receiver's voice-activity flag, with a hangover period after speech ends.
- Buffers captured words in a small FIFO and drives a req/ack DMA handshake with burst thresholding and flush-on-idle.
- Owns the receiver's `en` input; sits in the audio front-end ahead of the feature-extraction DMA channel.

---
 rtl/i2s_capture_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_ctrl.sv
// Capture sequencer between the I2S microphone receiver and the DMA channel:
// voice-activity gated capture with hangover, word FIFO and burst/flush DMA requests.
module i2s_capture_ctrl #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 8,
  parameter int BURST        = 4,
  parameter int HANG_SAMPLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  output logic                     i2s_en,
  input  logic                     i2s_done,
  input  logic [31:0]              i2s_data,
  input  logic                     vad_active,
  output logic                     dma_req,
  input  logic                     dma_ack,
  output logic [DATA_W-1:0]        dma_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               seg_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HANG_SAMPLES + 1);

  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] BURST_L   = LVL_W'(BURST);
  localparam logic [HC_W-1:0]  HANG_INIT = HC_W'(HANG_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LISTEN  = 3'd1,
    CAPTURE = 3'd2,
    HANG    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hang_q, hang_d;
  logic [7:0]        seg_q, seg_d;
  logic              ovf_q, ovf_d;
  logic              en_q, en_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic push_s, pop_s, full_s, wr_en_s;

  // Sequencer next state, push decision and FIFO bookkeeping.
  always_comb begin
    state_d = state_q;
    hang_d  = hang_q;
    seg_d   = seg_q;
    ovf_d   = ovf_q;
    push_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LISTEN;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LISTEN: begin
        if (i2s_done && vad_active) begin
          push_s  = 1'b1;
          state_d = CAPTURE;
          seg_d   = stop ? seg_q : seg_q + 8'd1;
        end else begin
          state_d = LISTEN;
        end
      end
      CAPTURE: begin
        if (i2s_done) begin
          push_s = 1'b1;
          if (!vad_active) begin
            state_d = HANG;
            hang_d  = HANG_INIT;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      HANG: begin
        if (i2s_done) begin
          push_s = 1'b1;
          if (vad_active) begin
            state_d = CAPTURE;
          end else if (hang_q == '0) begin
            state_d = LISTEN;
          end else begin
            hang_d = hang_q - HC_W'(1);
          end
        end else begin
          state_d = HANG;
        end
      end
      DRAIN: begin
        if (lvl_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // stop wins over any capture transition, but a coincident word still lands.
    if (stop && (state_q == LISTEN || state_q == CAPTURE || state_q == HANG)) begin
      state_d = DRAIN;
    end else begin
      state_d = state_d;
    end

    pop_s   = dma_ack && (lvl_q != '0);
    full_s  = (lvl_q == DEPTH_L);
    wr_en_s = push_s && (!full_s || pop_s);

    if (push_s && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    wr_d = wr_en_s ? wr_q + PTR_W'(1) : wr_q;
    rd_d = pop_s ? rd_q + PTR_W'(1) : rd_q;

    case ({wr_en_s, pop_s})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase

    en_d = (state_q == LISTEN) || (state_q == CAPTURE) || (state_q == HANG);
  end

  // Control and FIFO pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hang_q  <= '0;
      seg_q   <= 8'd0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      hang_q  <= hang_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
    end
  end

  // Word storage; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_q] <= i2s_data[31 -: DATA_W];
    end
  end

  assign i2s_en     = en_q;
  assign busy       = (state_q != IDLE);
  assign dma_req    = (lvl_q >= BURST_L) ||
                      ((lvl_q != '0) && (state_q == LISTEN || state_q == DRAIN));
  assign dma_data   = mem_q[rd_q];
  assign fifo_level = lvl_q;
  assign seg_count  = seg_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl with default parameters
// (DATA_W 24, DEPTH 8, BURST 4, HANG_SAMPLES 16).
module tb_i2s_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, i2s_done, vad_active, dma_ack;
  logic [31:0] i2s_data;
  logic        i2s_en, dma_req, overflow, busy;
  logic [23:0] dma_data;
  logic [3:0]  fifo_level;
  logic [7:0]  seg_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  i2s_capture_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .i2s_en     (i2s_en),
    .i2s_done   (i2s_done),
    .i2s_data   (i2s_data),
    .vad_active (vad_active),
    .dma_req    (dma_req),
    .dma_ack    (dma_ack),
    .dma_data   (dma_data),
    .fifo_level (fifo_level),
    .seg_count  (seg_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then release the pulses; outputs settle at #1 after the edge.
  task automatic step(input logic st, input logic sp, input logic dn,
                      input logic [31:0] d, input logic v, input logic ack);
    start = st; stop = sp; i2s_done = dn; i2s_data = d; vad_active = v; dma_ack = ack;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; i2s_done = 1'b0; dma_ack = 1'b0;
  endtask

  function automatic logic [31:0] dword(input logic [7:0] tag, input int k);
    return {tag, 16'(k), 8'h5A};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; i2s_done = 1'b0;
    i2s_data = 32'h0; vad_active = 1'b0; dma_ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_en", 32'(i2s_en), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_req", 32'(dma_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_seg", 32'(seg_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // Speech-active words while IDLE must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'hDEADBE00, 1'b1, 1'b0);
    chk("idle_en", 32'(i2s_en), 32'h0);
    chk("idle_level", 32'(fifo_level), 32'h0);
    chk("idle_req", 32'(dma_req), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // start with stop in the same cycle stays IDLE.
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("startstop_busy", 32'(busy), 32'h0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("listen_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("listen_en", 32'(i2s_en), 32'h1);

    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b1, 32'hA5A5A500 + 32'(n), 1'b0, 1'b0);
    chk("listen_discard", 32'(fifo_level), 32'h0);
    chk("listen_seg", 32'(seg_count), 32'h0);

    for (int n = 0; n < 6; n++) begin
      step(1'b0, 1'b0, 1'b1, 32'hA5A5A500 + 32'(n), 1'b1, 1'b0);
      if (n == 2) chk("burst_req_lvl3", 32'(dma_req), 32'h0);
      if (n == 3) chk("burst_req_lvl4", 32'(dma_req), 32'h1);
    end
    chk("seg_level", 32'(fifo_level), 32'h6);
    chk("seg_count1", 32'(seg_count), 32'h1);
    chk("seg_head", 32'(dma_data), 32'h00A5A5A5);

    // Falling word plus 16 hangover words, each hangover word paired with a pop.
    step(1'b0, 1'b0, 1'b1, 32'h11111100, 1'b0, 1'b0);
    chk("hang_fall_level", 32'(fifo_level), 32'h7);
    for (int k = 1; k <= 16; k++) step(1'b0, 1'b0, 1'b1, dword(8'h20, k), 1'b0, 1'b1);
    chk("hang_level", 32'(fifo_level), 32'h7);
    step(1'b0, 1'b0, 1'b1, dword(8'h20, 99), 1'b0, 1'b0);
    chk("hang_exact17", 32'(fifo_level), 32'h7);
    chk("hang_head", 32'(dma_data), 32'h0020000A);
    chk("hang_busy", 32'(busy), 32'h1);
    chk("hang_seg", 32'(seg_count), 32'h1);

    // Flush of the tail in LISTEN, below the burst threshold.
    for (int k = 0; k < 7; k++) begin
      if (k == 4) chk("flush_req_lvl3", 32'(dma_req), 32'h1);
      if (k == 6) chk("flush_head_last", 32'(dma_data), 32'h00200010);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("flush_level", 32'(fifo_level), 32'h0);
    chk("flush_req_empty", 32'(dma_req), 32'h0);

    // Ack on an empty FIFO is ignored.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("ack_empty_level", 32'(fifo_level), 32'h0);

    // New segment, re-trigger after 5 hangover samples, then overflow.
    step(1'b0, 1'b0, 1'b1, dword(8'hE0, 0), 1'b1, 1'b0);
    chk("seg_count2", 32'(seg_count), 32'h2);
    step(1'b0, 1'b0, 1'b1, dword(8'hE0, 1), 1'b0, 1'b0);
    for (int j = 2; j <= 6; j++) step(1'b0, 1'b0, 1'b1, dword(8'hE0, j), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, dword(8'hE0, 7), 1'b1, 1'b0);
    chk("retrig_seg", 32'(seg_count), 32'h2);
    chk("retrig_level", 32'(fifo_level), 32'h8);
    chk("retrig_ovf", 32'(overflow), 32'h0);
    step(1'b0, 1'b0, 1'b1, dword(8'hE0, 8), 1'b1, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_level", 32'(fifo_level), 32'h8);
    step(1'b0, 1'b0, 1'b1, dword(8'hE0, 9), 1'b1, 1'b1);
    chk("full_pushpop_level", 32'(fifo_level), 32'h8);
    chk("full_pushpop_head", 32'(dma_data), 32'h00E00001);

    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("pre_stop_head", 32'(dma_data), 32'h00E00006);

    // stop coincident with a push: word kept, then drain.
    step(1'b0, 1'b1, 1'b1, dword(8'hE0, 10), 1'b1, 1'b0);
    chk("stop_level", 32'(fifo_level), 32'h4);
    chk("stop_busy", 32'(busy), 32'h1);
    chk("drain_head0", 32'(dma_data), 32'h00E00006);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_en", 32'(i2s_en), 32'h0);
    chk("drain_req", 32'(dma_req), 32'h1);
    chk("drain_head1", 32'(dma_data), 32'h00E00007);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_head2", 32'(dma_data), 32'h00E00009);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_head3", 32'(dma_data), 32'h00E0000A);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_level", 32'(fifo_level), 32'h0);
    chk("drain_req_empty", 32'(dma_req), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drain_idle", 32'(busy), 32'h0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("start_clr_ovf", 32'(overflow), 32'h0);

    // Reset in the middle of a capture discards everything.
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b1, dword(8'hC0, j), 1'b1, 1'b0);
    chk("pre_rst_req", 32'(dma_req), 32'h1);
    chk("pre_rst_seg", 32'(seg_count), 32'h3);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_en", 32'(i2s_en), 32'h0);
    chk("mid_rst_req", 32'(dma_req), 32'h0);
    chk("mid_rst_level", 32'(fifo_level), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_seg", 32'(seg_count), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
